// File: rtl/shift_reg_pkg.sv
// Shared constants for the universal shift register: mode encodings and
// the bit-counter width helper.
package shift_reg_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHL   = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_ROL   = 3'b011,
    MODE_ROR   = 3'b100,
    MODE_LOAD  = 3'b101,
    MODE_CLEAR = 3'b110,
    MODE_RSVD  = 3'b111
  } mode_e;

  // Bits needed to count 0..w-1, never less than one.
  function automatic int cnt_width(input int w);
    int r;
    r = 1;
    while ((1 << r) < w) r++;
    return r;
  endfunction

endpackage

// File: rtl/sr_bit_counter.sv
// Counts shift operations within a frame; wraps at WIDTH-1 and emits a
// single-cycle done pulse in the cycle after the wrapping shift.
module sr_bit_counter
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // Clear wins over increment so LOAD/CLEAR never produce a frame pulse.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = done_q;

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: shift/rotate both ways, parallel load, clear,
// with a serial-out bit and frame counting through sr_bit_counter.
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sdin,
  input  logic [WIDTH-1:0] pdin,
  output logic [WIDTH-1:0] dout,
  output logic             sdout,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             frame_done
);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             sdout_q, sdout_d;
  logic             shift_op;
  logic             clr_op;
  mode_e            mode_sel;

  assign mode_sel = mode_e'(mode);

  always_comb begin
    dout_d   = dout_q;
    sdout_d  = sdout_q;
    shift_op = 1'b0;
    clr_op   = 1'b0;
    if (en) begin
      case (mode_sel)
        MODE_SHL: begin
          dout_d   = {dout_q[WIDTH-2:0], sdin};
          sdout_d  = dout_q[WIDTH-1];
          shift_op = 1'b1;
        end
        MODE_SHR: begin
          dout_d   = {sdin, dout_q[WIDTH-1:1]};
          sdout_d  = dout_q[0];
          shift_op = 1'b1;
        end
        MODE_ROL: begin
          dout_d   = {dout_q[WIDTH-2:0], dout_q[WIDTH-1]};
          sdout_d  = dout_q[WIDTH-1];
          shift_op = 1'b1;
        end
        MODE_ROR: begin
          dout_d   = {dout_q[0], dout_q[WIDTH-1:1]};
          sdout_d  = dout_q[0];
          shift_op = 1'b1;
        end
        MODE_LOAD: begin
          dout_d = pdin;
          clr_op = 1'b1;
        end
        MODE_CLEAR: begin
          dout_d = '0;
          clr_op = 1'b1;
        end
        MODE_HOLD, MODE_RSVD: begin
          dout_d = dout_q;
        end
        default: begin
          dout_d = dout_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q  <= '0;
      sdout_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      sdout_q <= sdout_d;
    end
  end

  sr_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (shift_op),
    .clr  (clr_op),
    .cnt  (bit_cnt),
    .done (frame_done)
  );

  assign dout  = dout_q;
  assign sdout = sdout_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Checks WIDTH=8 and WIDTH=4 instances against an arithmetic reference model
// using directed scenarios followed by randomized operation.
module tb_shift_reg_univ;
  import shift_reg_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       en8 = 1'b0, sdin8 = 1'b0;
  logic [2:0] mode8 = 3'b000;
  logic [7:0] pdin8 = 8'h00;
  logic [7:0] dout8;
  logic       sdout8, done8;
  logic [2:0] cnt8;

  logic       en4 = 1'b0, sdin4 = 1'b0;
  logic [2:0] mode4 = 3'b000;
  logic [3:0] pdin4 = 4'h0;
  logic [3:0] dout4;
  logic       sdout4, done4;
  logic [1:0] cnt4;

  int total = 0;
  int bad   = 0;

  longint m_d[2];
  int     m_sd[2];
  int     m_cnt[2];
  int     m_done[2];

  always #5 clk = ~clk;

  shift_reg_univ #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .mode(mode8), .sdin(sdin8), .pdin(pdin8),
    .dout(dout8), .sdout(sdout8), .bit_cnt(cnt8), .frame_done(done8)
  );

  shift_reg_univ #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .mode(mode4), .sdin(sdin4), .pdin(pdin4),
    .dout(dout4), .sdout(sdout4), .bit_cnt(cnt4), .frame_done(done4)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_d[i] = 0; m_sd[i] = 0; m_cnt[i] = 0; m_done[i] = 0;
    end
  endtask

  // Register value treated as an integer modulo 2**w; shifts are *2 and /2.
  task automatic model_step(input int i, input logic e, input logic [2:0] md,
                            input logic s, input longint p);
    int     w;
    longint modv, half, d;
    bit     shifted;
    w = (i == 0) ? 8 : 4;
    modv = longint'(1) << w;
    half = modv / 2;
    d = m_d[i];
    shifted = 0;
    m_done[i] = 0;
    if (e) begin
      case (md)
        3'd1: begin m_sd[i] = int'(d / half); m_d[i] = (d * 2) % modv + s; shifted = 1; end
        3'd2: begin m_sd[i] = int'(d % 2); m_d[i] = d / 2 + (s ? half : 0); shifted = 1; end
        3'd3: begin m_sd[i] = int'(d / half); m_d[i] = (d * 2) % modv + d / half; shifted = 1; end
        3'd4: begin m_sd[i] = int'(d % 2); m_d[i] = d / 2 + (d % 2) * half; shifted = 1; end
        3'd5: begin m_d[i] = p % modv; m_cnt[i] = 0; end
        3'd6: begin m_d[i] = 0; m_cnt[i] = 0; end
        default: ;
      endcase
    end
    if (shifted) begin
      m_cnt[i]++;
      if (m_cnt[i] == w) begin
        m_cnt[i] = 0;
        m_done[i] = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("dout8", dout8, m_d[0]);
    chk("sdout8", sdout8, m_sd[0]);
    chk("cnt8", cnt8, m_cnt[0]);
    chk("done8", done8, m_done[0]);
    chk("dout4", dout4, m_d[1]);
    chk("sdout4", sdout4, m_sd[1]);
    chk("cnt4", cnt4, m_cnt[1]);
    chk("done4", done4, m_done[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, en8, mode8, sdin8, longint'(pdin8));
    model_step(1, en4, mode4, sdin4, longint'(pdin4));
    #1;
    check_all();
  endtask

  task automatic op8(input logic e, input logic [2:0] md, input logic s,
                     input logic [7:0] p);
    en8 = e; mode8 = md; sdin8 = s; pdin8 = p;
    tick();
  endtask

  logic [7:0] seq25;
  int         pulses;

  initial begin
    model_reset();
    #1;
    check_all();
    #11 rst = 1'b1;

    // Serial frame of 8 SHL ops
    seq25 = 8'b1011_0010;
    for (int k = 7; k >= 0; k--) op8(1'b1, MODE_SHL, seq25[k], 8'h00);
    chk("frame_b2_dout", dout8, 64'hB2);
    chk("frame_b2_cnt", cnt8, 0);
    chk("frame_b2_done", done8, 1);
    op8(1'b1, MODE_HOLD, 1'b0, 8'h00);
    chk("frame_b2_done_drop", done8, 0);

    // Load then rotate each way
    op8(1'b1, MODE_LOAD, 1'b0, 8'hA5);
    op8(1'b1, MODE_ROL, 1'b0, 8'h00);
    chk("rol_dout", dout8, 64'h4B);
    chk("rol_sdout", sdout8, 1);
    op8(1'b1, MODE_ROR, 1'b0, 8'h00);
    chk("ror_dout", dout8, 64'hA5);
    chk("ror_sdout", sdout8, 1);
    chk("ror_cnt", cnt8, 2);

    // SHR with ones from a cleared register
    op8(1'b1, MODE_CLEAR, 1'b0, 8'h00);
    repeat (3) op8(1'b1, MODE_SHR, 1'b1, 8'h00);
    chk("shr_dout", dout8, 64'hE0);
    chk("shr_sdout", sdout8, 0);
    chk("shr_cnt", cnt8, 3);

    // Disabled, reserved mode, then clear at the last count
    repeat (4) op8(1'b0, MODE_SHL, 1'b1, 8'hFF);
    chk("en0_dout", dout8, 64'hE0);
    chk("en0_cnt", cnt8, 3);
    op8(1'b1, MODE_RSVD, 1'b1, 8'hFF);
    chk("rsvd_dout", dout8, 64'hE0);
    repeat (4) op8(1'b1, MODE_SHL, 1'b1, 8'h00);
    chk("pre_clr_cnt", cnt8, 7);
    op8(1'b1, MODE_CLEAR, 1'b1, 8'h00);
    chk("clr_dout", dout8, 0);
    chk("clr_cnt", cnt8, 0);
    chk("clr_done", done8, 0);

    // Asynchronous reset in the middle of a frame
    repeat (5) op8(1'b1, MODE_ROL, 1'b1, 8'h00);
    op8(1'b1, MODE_LOAD, 1'b0, 8'h3C);
    repeat (5) op8(1'b1, MODE_SHR, 1'b1, 8'h00);
    en8 = 1'b0;
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_dout", dout8, 0);
    chk("rst_sdout", sdout8, 0);
    chk("rst_cnt", cnt8, 0);
    chk("rst_done", done8, 0);
    #2 rst = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      op8(1'b1, MODE_SHL, 1'b1, 8'h00);
      if (k < 7) pulses += int'(done8);
    end
    chk("rst_no_early_done", pulses, 0);
    chk("rst_frame_done", done8, 1);

    // Narrow instance: one frame of ones, then two back-to-back frames
    en8 = 1'b0;
    en4 = 1'b1; mode4 = MODE_SHL; sdin4 = 1'b1;
    repeat (4) tick();
    chk("w4_dout", dout4, 64'hF);
    chk("w4_done", done4, 1);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      sdin4 = 1'($urandom_range(1));
      mode4 = (k % 2 == 0) ? MODE_ROR : MODE_SHL;
      tick();
      pulses += int'(done4);
    end
    chk("w4_pulses", pulses, 2);

    // Randomized operation on both instances
    for (int k = 0; k < 600; k++) begin
      en8 = ($urandom_range(9) != 0);
      mode8 = 3'($urandom_range(7));
      if (mode8 inside {MODE_LOAD, MODE_CLEAR} && $urandom_range(3) != 0)
        mode8 = MODE_SHL;
      sdin8 = 1'($urandom_range(1));
      pdin8 = 8'($urandom);
      en4 = ($urandom_range(9) != 0);
      mode4 = 3'($urandom_range(7));
      sdin4 = 1'($urandom_range(1));
      pdin4 = 4'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_reg_univ.md
SHIFT_REG_UNIV -- requirements
Module: shift_reg_univ

Interface
- REQ-001 The block SHALL have parameter WIDTH, default 8, register width in bits; legal range 2..64.
- REQ-002 The block SHALL have derived localparam CNT_W = clog2(WIDTH), minimum 1, giving the bit-counter width.
- REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
- REQ-004 The block SHALL have port rst, input, 1, asynchronous active-low reset.
- REQ-005 The block SHALL have port en, input, 1, operation enable; 0 holds all state.
- REQ-006 The block SHALL have port mode, input, 3, operation select per REQ-011.
- REQ-007 The block SHALL have port sdin, input, 1, serial data in.
- REQ-008 The block SHALL have port pdin, input, WIDTH, parallel load data.
- REQ-009 The block SHALL have ports dout, output, WIDTH, register contents; sdout, output, 1, last bit shifted or rotated out.
- REQ-010 The block SHALL have ports bit_cnt, output, CNT_W, shifts since last frame boundary; frame_done, output, 1, one-cycle frame-complete pulse.

Function
- REQ-011 With en=1, the mode encoding SHALL be:
  - 000 HOLD
  - 001 SHL: dout <= {dout[W-2:0], sdin}
  - 010 SHR: dout <= {sdin, dout[W-1:1]}
  - 011 ROL: dout <= {dout[W-2:0], dout[W-1]}
  - 100 ROR: dout <= {dout[0], dout[W-1:1]}
  - 101 LOAD: dout <= pdin
  - 110 CLEAR: dout <= 0
  - 111 reserved, behaves as HOLD.
- REQ-012 Register updates SHALL have 1-cycle latency: a new dout is visible after the rising edge that sampled mode, en, sdin and pdin.
- REQ-013 On SHL and ROL, sdout SHALL be set to the old dout[W-1]; on SHR and ROR, to the old dout[0]; in all other modes sdout SHALL hold.
- REQ-014 SHL, SHR, ROL and ROR with en=1 are "shift ops"; each SHALL increment bit_cnt.
- REQ-015 A shift op while bit_cnt==WIDTH-1 SHALL wrap bit_cnt to 0 and set frame_done=1 for exactly the following cycle.
- REQ-016 frame_done SHALL be 0 in every cycle not covered by REQ-015, including back-to-back frames.
- REQ-017 LOAD and CLEAR SHALL force bit_cnt to 0 and SHALL NOT assert frame_done, even if bit_cnt==WIDTH-1.
- REQ-018 With en=0, dout, sdout and bit_cnt SHALL hold regardless of mode, and frame_done SHALL be 0 in the next cycle.
- REQ-019 Mixing shift directions within a frame SHALL count every shift op toward the same frame.

Reset
- REQ-020 When rst=0, dout, sdout, bit_cnt and frame_done SHALL go to 0 immediately, independent of clk.
- REQ-021 Assertion of rst mid-frame SHALL discard the partial frame; counting SHALL restart from 0 after release.
- REQ-022 The first rising edge after rst returns to 1 SHALL perform a normal operation.

Structure
- REQ-023 The mode encodings SHALL be constants in shared package shift_reg_pkg.
- REQ-024 The bit counter with wrap and frame_done generation SHALL be sub-module sr_bit_counter (ports clk, rst, inc, clr, cnt, done); the data path SHALL stay in shift_reg_univ.

Verification
- REQ-025 WIDTH=8, SHL, sdin sequence 1,0,1,1,0,0,1,0 -> dout=8'hB2, bit_cnt=0, frame_done high exactly 1 cycle after the 8th shift.
- REQ-026 LOAD 8'hA5, then ROL -> dout=8'h4B and sdout=1; then ROR -> dout=8'hA5 and sdout=1; bit_cnt=2.
- REQ-027 From 8'h00, SHR with sdin=1 for 3 cycles -> dout=8'hE0, sdout=0, bit_cnt=3.
- REQ-028 Hold and clear cases:
  - en=0 with mode=SHL for 4 cycles -> dout and bit_cnt unchanged.
  - mode=111 -> hold.
  - CLEAR at bit_cnt=7 -> dout=0, bit_cnt=0, no frame_done.
- REQ-029 Reset mid-frame: rst=0 for 3 ns between edges after 5 shifts -> all outputs 0 immediately; 8 further shifts are required for the next frame_done.
- REQ-030 WIDTH=4 instance: 4 SHL of 1 -> dout=4'hF and frame_done pulse; 8 continuous shifts -> exactly 2 single-cycle pulses.
